// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined integer ALU with valid/ready handshake.
//
// Operations (ctrl_ALUopcode):
//   00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA.
//   Any other code yields data_result = 0 and overflow = 0. The flags are
//   still computed and the tag is still returned.
//
// Pipeline:
//   Stage 1 registers the following:
//     - the upper operand halves, the opcode and the tag;
//     - the low-half sum and its carry;
//     - the low-half A-B used by the flags, and its carry;
//     - the logic/shift result.
//   Stage 2 finishes both upper halves from the registered mid carries. It
//   registers the result and the flags straight onto the outputs.
//   Latency is 2 cycles from accept to out_valid. Throughput is 1 op/cycle.
//
// Ports:
//   clock, ctrl_reset_n                 clock, asynchronous active-low reset
//   in_valid / in_ready                 operation handshake (in_ready is
//                                       combinational from out_ready)
//   data_operandA, data_operandB        signed operands
//   ctrl_ALUopcode, ctrl_shiftamt       operation select, shift distance
//   in_tag / out_tag                    sideband carried with each op
//   out_valid / out_ready               result handshake
//   data_result                         result
//   isNotEqual, isLessThan              A != B, signed A < B (any opcode)
//   overflow                            signed overflow for ADD/SUB only
//
// WIDTH must be an even multiple of BLOCK.
// ----------------------------------------------------------------------------

// Carry-select adder. Each BLOCK-bit slice is added twice, once with a carry
// in of 0 and once with a carry in of 1. The incoming block carry then picks
// one of the two copies.
module alu_pipe_csel_add #(
    parameter int W     = 16,
    parameter int BLOCK = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int NB = W / BLOCK;

    logic [NB:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi = gi + 1) begin : g_blk
            logic [BLOCK:0] sum0;
            logic [BLOCK:0] sum1;

            assign sum0 = {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, b[gi*BLOCK +: BLOCK]};
            assign sum1 = {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, b[gi*BLOCK +: BLOCK]}
                        + {{BLOCK{1'b0}}, 1'b1};

            assign sum[gi*BLOCK +: BLOCK] = carry[gi] ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
            assign carry[gi+1]            = carry[gi] ? sum1[BLOCK]     : sum0[BLOCK];
        end
    endgenerate

    assign cout = carry[NB];
endmodule

module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_operandA,
    input  logic [WIDTH-1:0]         data_operandB,
    input  logic [4:0]               ctrl_ALUopcode,
    input  logic [$clog2(WIDTH)-1:0] ctrl_shiftamt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_result,
    output logic                     isNotEqual,
    output logic                     isLessThan,
    output logic                     overflow,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int HALF = WIDTH / 2;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    // ---------------- handshake ----------------
    logic s1_valid_reg;
    logic out_valid_reg;
    logic s2_ready;

    // A stage loads when it is empty or when its content moves on this cycle.
    assign s2_ready = ~out_valid_reg | out_ready;
    assign in_ready = ~s1_valid_reg | s2_ready;

    // ---------------- stage 1 combinational ----------------
    logic             s1_sub;
    logic [WIDTH-1:0] b_eff;
    logic [HALF-1:0]  lo_sum;
    logic             lo_carry;
    logic [HALF-1:0]  lo_diff;
    logic             lo_diff_carry;
    logic [WIDTH-1:0] logic_next;

    assign s1_sub = (ctrl_ALUopcode == OP_SUB);
    assign b_eff  = data_operandB ^ {WIDTH{s1_sub}};

    // Low half of the opcode's sum: SUB takes inverted B with a carry in of 1.
    alu_pipe_csel_add #(.W(HALF), .BLOCK(BLOCK)) u_lo_sum (
        .a    (data_operandA[HALF-1:0]),
        .b    (b_eff[HALF-1:0]),
        .cin  (s1_sub),
        .sum  (lo_sum),
        .cout (lo_carry)
    );

    // Low half of A-B for the flags. The flags use A-B for every opcode.
    alu_pipe_csel_add #(.W(HALF), .BLOCK(BLOCK)) u_lo_diff (
        .a    (data_operandA[HALF-1:0]),
        .b    (~data_operandB[HALF-1:0]),
        .cin  (1'b1),
        .sum  (lo_diff),
        .cout (lo_diff_carry)
    );

    always_comb begin
        logic_next = '0;
        case (ctrl_ALUopcode)
            OP_AND:  logic_next = data_operandA & data_operandB;
            OP_OR:   logic_next = data_operandA | data_operandB;
            OP_SLL:  logic_next = data_operandA << ctrl_shiftamt;
            OP_SRA:  logic_next = $signed(data_operandA) >>> ctrl_shiftamt;
            default: logic_next = '0;
        endcase
    end

    // ---------------- stage 1 registers ----------------
    logic [HALF-1:0]  a_hi_reg;
    logic [HALF-1:0]  b_hi_reg;          // upper half of B, inverted for SUB
    logic [4:0]       op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [HALF-1:0]  lo_sum_reg;
    logic             mid_carry_reg;
    logic [HALF-1:0]  lo_diff_reg;
    logic             diff_mid_carry_reg;
    logic [WIDTH-1:0] logic_reg;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            s1_valid_reg       <= 1'b0;
            a_hi_reg           <= '0;
            b_hi_reg           <= '0;
            op_reg             <= '0;
            tag_reg            <= '0;
            lo_sum_reg         <= '0;
            mid_carry_reg      <= 1'b0;
            lo_diff_reg        <= '0;
            diff_mid_carry_reg <= 1'b0;
            logic_reg          <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                a_hi_reg           <= data_operandA[WIDTH-1:HALF];
                b_hi_reg           <= b_eff[WIDTH-1:HALF];
                op_reg             <= ctrl_ALUopcode;
                tag_reg            <= in_tag;
                lo_sum_reg         <= lo_sum;
                mid_carry_reg      <= lo_carry;
                lo_diff_reg        <= lo_diff;
                diff_mid_carry_reg <= lo_diff_carry;
                logic_reg          <= logic_next;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic             s2_sub;
    logic             s2_addsub;
    logic [HALF-1:0]  nb_hi;
    logic [HALF-1:0]  hi_sum;
    logic             hi_carry;
    logic [HALF-1:0]  hi_diff;
    logic             hi_diff_carry;
    logic [WIDTH-1:0] result_next;
    logic             ovf_next;
    logic             neq_next;
    logic             lt_next;

    assign s2_sub    = (op_reg == OP_SUB);
    assign s2_addsub = (op_reg == OP_ADD) | s2_sub;

    // Recover ~B from the stored B'. For SUB, B' already is ~B.
    assign nb_hi = s2_sub ? b_hi_reg : ~b_hi_reg;

    alu_pipe_csel_add #(.W(HALF), .BLOCK(BLOCK)) u_hi_sum (
        .a    (a_hi_reg),
        .b    (b_hi_reg),
        .cin  (mid_carry_reg),
        .sum  (hi_sum),
        .cout (hi_carry)
    );

    alu_pipe_csel_add #(.W(HALF), .BLOCK(BLOCK)) u_hi_diff (
        .a    (a_hi_reg),
        .b    (nb_hi),
        .cin  (diff_mid_carry_reg),
        .sum  (hi_diff),
        .cout (hi_diff_carry)
    );

    // a^b'^s at the MSB is the carry into the MSB. XOR with the carry out
    // gives signed overflow. This matches
    // (A[MSB]==B'[MSB]) & (S[MSB]!=A[MSB]).
    assign ovf_next = s2_addsub
                    & (a_hi_reg[HALF-1] ^ b_hi_reg[HALF-1] ^ hi_sum[HALF-1] ^ hi_carry);

    assign neq_next = |{hi_diff, lo_diff_reg};

    // Signed less-than: take the unsigned borrow (~carry out of A + ~B + 1)
    // and flip it when the operand signs differ. This is equal to
    // diff[MSB] ^ ovf(A-B).
    assign lt_next = a_hi_reg[HALF-1] ^ ~nb_hi[HALF-1] ^ ~hi_diff_carry;

    always_comb begin
        result_next = '0;
        case (op_reg)
            OP_ADD, OP_SUB:                 result_next = {hi_sum, lo_sum_reg};
            OP_AND, OP_OR, OP_SLL, OP_SRA:  result_next = logic_reg;
            default:                        result_next = '0;
        endcase
    end

    // ---------------- stage 2 / output registers ----------------
    logic [WIDTH-1:0] result_reg;
    logic             neq_reg;
    logic             lt_reg;
    logic             ovf_reg;
    logic [TAG_W-1:0] out_tag_reg;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            neq_reg       <= 1'b0;
            lt_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            out_tag_reg   <= '0;
        end else if (s2_ready) begin
            out_valid_reg <= s1_valid_reg;
            // Bubbles leave the data registers alone, so the last result stays put.
            if (s1_valid_reg) begin
                result_reg  <= result_next;
                neq_reg     <= neq_next;
                lt_reg      <= lt_next;
                ovf_reg     <= ovf_next;
                out_tag_reg <= tag_reg;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign data_result = result_reg;
    assign isNotEqual  = neq_reg;
    assign isLessThan  = lt_reg;
    assign overflow    = ovf_reg;
    assign out_tag     = out_tag_reg;
endmodule
